// File: rtl/poly_pkg.sv
// ----------------------------------------------------------------------------
// poly_pkg
// Shared types for the Horner polynomial evaluator.
//   state_t  : sequencing states of the load / compute FSM
//   alu_op_t : operation selected on the single shared multiply/add ALU
// ----------------------------------------------------------------------------
package poly_pkg;

    typedef enum logic [2:0] {
        LOAD_COEF,
        COEF_WAIT,
        LOAD_X,
        X_WAIT,
        INIT,
        MUL,
        ADD,
        DONE
    } state_t;

    typedef enum logic {
        OP_ADD,
        OP_MUL
    } alu_op_t;

endpackage

// File: rtl/poly_eval_datapath.sv
// ----------------------------------------------------------------------------
// poly_eval_datapath
// Storage and arithmetic for the Horner evaluator: coefficient register file,
// x register, accumulator, one shared multiply/add ALU, sticky overflow and
// the result register. All sequencing comes from the FSM in the top module.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   data_in      : value being loaded (coefficient or x)
//   coef_we      : write data_in into coef[coef_sel]
//   coef_sel     : coefficient write index
//   x_we         : write data_in into x
//   acc_init     : acc <= coef[DEGREE], clear overflow
//   alu_en       : acc <= ALU result, accumulate overflow
//   alu_op       : OP_MUL (acc*x) or OP_ADD (acc+coef[step_sel])
//   step_sel     : coefficient read index for OP_ADD
//   result_we    : capture the ALU result into data_result
//   data_result  : last completed result
//   overflow     : sticky overflow of the current/last evaluation
// ----------------------------------------------------------------------------
module poly_eval_datapath
    import poly_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 2,
    parameter int IDX_W  = $clog2(DEGREE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             coef_we,
    input  logic [IDX_W-1:0] coef_sel,
    input  logic             x_we,
    input  logic             acc_init,
    input  logic             alu_en,
    input  alu_op_t          alu_op,
    input  logic [IDX_W-1:0] step_sel,
    input  logic             result_we,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow
);

    logic [WIDTH-1:0]   coef [DEGREE+1];
    logic [WIDTH-1:0]   x_reg;
    logic [WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_ovf;

    // Shared ALU. The full double-width product is formed so that any bit
    // above WIDTH can be flagged; the stored result is always truncated.
    always_comb begin
        product    = acc * x_reg;
        sum        = {1'b0, acc} + {1'b0, coef[step_sel]};
        alu_result = sum[WIDTH-1:0];
        alu_ovf    = sum[WIDTH];
        if (alu_op == OP_MUL) begin
            alu_result = product[WIDTH-1:0];
            alu_ovf    = |product[2*WIDTH-1:WIDTH];
        end
    end

    // Coefficient file and x register, written one value per Go pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= DEGREE; i++) begin
                coef[i] <= '0;
            end
            x_reg <= '0;
        end else begin
            if (coef_we) begin
                coef[coef_sel] <= data_in;
            end
            if (x_we) begin
                x_reg <= data_in;
            end
        end
    end

    // Accumulator and sticky overflow. INIT seeds acc with the leading
    // coefficient and starts a fresh overflow history for this evaluation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (acc_init) begin
            acc      <= coef[DEGREE];
            overflow <= 1'b0;
        end else if (alu_en) begin
            acc      <= alu_result;
            overflow <= overflow | alu_ovf;
        end
    end

    // Result register only changes when an evaluation completes, so the
    // previous answer stays visible through the next load and compute.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_result <= '0;
        end else if (result_we) begin
            data_result <= alu_result;
        end
    end

endmodule

// File: rtl/poly_eval_horner.sv
// ----------------------------------------------------------------------------
// poly_eval_horner
// Evaluates P(x) = a_D*x^D + ... + a_0 with Horner's method. Coefficients
// (a_D first) and then x are loaded one per Go pulse; the FSM then alternates
// MUL and ADD on the shared datapath.
// Ports:
//   Clock       : system clock
//   Reset       : asynchronous active-high reset
//   Go          : push-button load strobe, one capture per high pulse
//   DataIn      : coefficient or x value
//   DataResult  : P(x) mod 2^WIDTH of the last completed evaluation
//   ResultValid : high in DONE only
//   Overflow    : any intermediate of the last evaluation exceeded WIDTH bits
//   Busy        : high during INIT, MUL and ADD
// ----------------------------------------------------------------------------
module poly_eval_horner
    import poly_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Go,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataResult,
    output logic             ResultValid,
    output logic             Overflow,
    output logic             Busy
);

    localparam int               IDX_W    = $clog2(DEGREE + 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DEGREE);
    localparam logic [IDX_W-1:0] STEP_TOP = IDX_W'(DEGREE - 1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] step;
    logic             coef_we;
    logic             x_we;
    logic             acc_init;
    logic             alu_en;
    alu_op_t          alu_op;
    logic             result_we;

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= LOAD_COEF;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath strobes. DONE shares the LOAD_COEF behaviour
    // because idx is already back at DEGREE when the evaluation finishes.
    always_comb begin
        next_state = state;
        coef_we    = 1'b0;
        x_we       = 1'b0;
        acc_init   = 1'b0;
        alu_en     = 1'b0;
        alu_op     = OP_ADD;
        result_we  = 1'b0;
        case (state)
            LOAD_COEF, DONE: begin
                if (Go) begin
                    coef_we    = 1'b1;
                    next_state = COEF_WAIT;
                end
            end
            COEF_WAIT: begin
                if (!Go) begin
                    next_state = (idx == '0) ? LOAD_X : LOAD_COEF;
                end
            end
            LOAD_X: begin
                if (Go) begin
                    x_we       = 1'b1;
                    next_state = X_WAIT;
                end
            end
            X_WAIT: begin
                if (!Go) begin
                    next_state = INIT;
                end
            end
            INIT: begin
                acc_init   = 1'b1;
                next_state = MUL;
            end
            MUL: begin
                alu_en     = 1'b1;
                alu_op     = OP_MUL;
                next_state = ADD;
            end
            ADD: begin
                alu_en = 1'b1;
                alu_op = OP_ADD;
                if (step == '0) begin
                    result_we  = 1'b1;
                    next_state = DONE;
                end else begin
                    next_state = MUL;
                end
            end
            default: begin
                next_state = LOAD_COEF;
            end
        endcase
    end

    // Load index and compute step. idx wraps back to DEGREE as the last
    // coefficient is released so the next load sequence starts at a_D.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            idx  <= IDX_TOP;
            step <= '0;
        end else begin
            case (state)
                COEF_WAIT: begin
                    if (!Go) begin
                        idx <= (idx == '0) ? IDX_TOP : idx - 1'b1;
                    end
                end
                INIT: begin
                    step <= STEP_TOP;
                end
                ADD: begin
                    if (step != '0) begin
                        step <= step - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ResultValid = (state == DONE);
    assign Busy        = (state == INIT) || (state == MUL) || (state == ADD);

    poly_eval_datapath #(
        .WIDTH  (WIDTH),
        .DEGREE (DEGREE),
        .IDX_W  (IDX_W)
    ) u_datapath (
        .clk         (Clock),
        .reset       (Reset),
        .data_in     (DataIn),
        .coef_we     (coef_we),
        .coef_sel    (idx),
        .x_we        (x_we),
        .acc_init    (acc_init),
        .alu_en      (alu_en),
        .alu_op      (alu_op),
        .step_sel    (step),
        .result_we   (result_we),
        .data_result (DataResult),
        .overflow    (Overflow)
    );

endmodule

// File: tb/tb_poly_eval_horner.sv
// ----------------------------------------------------------------------------
// tb_poly_eval_horner
// Drives a DEGREE=2 and a DEGREE=3 evaluator with directed loads. Expected
// results are queued when a load sequence is issued; a monitor pops and
// compares whenever ResultValid rises.
// ----------------------------------------------------------------------------
module tb_poly_eval_horner;

    typedef struct {
        logic [7:0] result;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       go_a;
    logic [7:0] data_a;
    logic [7:0] res_a;
    logic       rv_a;
    logic       ovf_a;
    logic       busy_a;
    logic       go_b;
    logic [7:0] data_b;
    logic [7:0] res_b;
    logic       rv_b;
    logic       ovf_b;
    logic       busy_b;

    int   compared;
    int   mismatched;
    exp_t q_a[$];
    exp_t q_b[$];
    logic prev_rv_a;
    logic prev_rv_b;
    int   edges;
    int   busy_cnt;

    poly_eval_horner #(.WIDTH(8), .DEGREE(2)) dut_d2 (
        .Clock       (clk),
        .Reset       (reset),
        .Go          (go_a),
        .DataIn      (data_a),
        .DataResult  (res_a),
        .ResultValid (rv_a),
        .Overflow    (ovf_a),
        .Busy        (busy_a)
    );

    poly_eval_horner #(.WIDTH(8), .DEGREE(3)) dut_d3 (
        .Clock       (clk),
        .Reset       (reset),
        .Go          (go_b),
        .DataIn      (data_b),
        .DataResult  (res_b),
        .ResultValid (rv_b),
        .Overflow    (ovf_b),
        .Busy        (busy_b)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One push-button press: Go high for 'hold' cycles while DataIn keeps
    // changing after the first cycle, then released. Returns on the negedge
    // after the edge that sees Go low.
    task automatic applyStimulus(input bit which, input logic [7:0] value, input int hold);
        logic [7:0] d;
        d = value;
        @(negedge clk);
        if (which) begin go_b = 1'b1; data_b = d; end
        else       begin go_a = 1'b1; data_a = d; end
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            d = d + 8'd37;
            if (which) data_b = d;
            else       data_a = d;
        end
        @(negedge clk);
        if (which) begin go_b = 1'b0; data_b = 8'hEE; end
        else       begin go_a = 1'b0; data_a = 8'hEE; end
        @(negedge clk);
    endtask

    // Loads n values: n-1 coefficients (highest first) followed by x.
    task automatic loadAll(input bit which, input logic [7:0] v [5], input int n, input int hold);
        for (int i = 0; i < n; i++) begin
            applyStimulus(which, v[i], hold);
        end
    endtask

    // Counts edges from the one that released x (counted as the first) until
    // ResultValid is seen, plus the cycles spent with Busy high.
    task automatic waitDone(input bit which, output int n_edges, output int n_busy);
        n_edges = 1;
        n_busy  = 0;
        while (((which ? rv_b : rv_a) == 1'b0) && n_edges < 100) begin
            if (which ? busy_b : busy_a) n_busy++;
            @(negedge clk);
            n_edges++;
        end
        if (n_edges >= 100) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL done_timeout_%0d: got no ResultValid in %0d edges, expected within 100", which, n_edges);
        end
    endtask

    task automatic pushA(input logic [7:0] r, input logic o);
        exp_t e;
        e.result = r;
        e.ovf    = o;
        q_a.push_back(e);
    endtask

    // Monitor: each rising ResultValid consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rv_a && !prev_rv_a) begin
            if (q_a.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result_a: got %0d, expected no result", res_a);
            end else begin
                e = q_a.pop_front();
                checkOutput("result_a", res_a, e.result);
                checkOutput("overflow_a", ovf_a, e.ovf);
            end
        end
        if (rv_b && !prev_rv_b) begin
            if (q_b.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result_b: got %0d, expected no result", res_b);
            end else begin
                e = q_b.pop_front();
                checkOutput("result_b", res_b, e.result);
                checkOutput("overflow_b", ovf_b, e.ovf);
            end
        end
        prev_rv_a = rv_a;
        prev_rv_b = rv_b;
    end

    // Directed scenarios.
    initial begin
        exp_t e;
        compared   = 0;
        mismatched = 0;
        prev_rv_a  = 1'b0;
        prev_rv_b  = 1'b0;
        reset      = 1'b1;
        go_a       = 1'b0;
        go_b       = 1'b0;
        data_a     = 8'h00;
        data_b     = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset_result", res_a, 0);
        checkOutput("reset_valid", rv_a, 0);
        checkOutput("reset_overflow", ovf_a, 0);
        checkOutput("reset_busy", busy_a, 0);
        reset = 1'b0;

        $display("[TB] scenario 1: 2x^2+3x+4 at x=5");
        pushA(8'd69, 1'b0);
        loadAll(1'b0, '{8'd2, 8'd3, 8'd4, 8'd5, 8'd0}, 4, 1);
        waitDone(1'b0, edges, busy_cnt);
        checkOutput("latency_s1", edges, 6);
        checkOutput("busy_cycles_s1", busy_cnt, 5);

        $display("[TB] scenario 2: 16x^2 at x=4 overflows");
        pushA(8'd0, 1'b1);
        loadAll(1'b0, '{8'd16, 8'd0, 8'd0, 8'd4, 8'd0}, 4, 1);
        waitDone(1'b0, edges, busy_cnt);

        $display("[TB] scenario 3: long Go hold with changing DataIn");
        pushA(8'd69, 1'b0);
        loadAll(1'b0, '{8'd2, 8'd3, 8'd4, 8'd5, 8'd0}, 4, 20);
        waitDone(1'b0, edges, busy_cnt);
        checkOutput("latency_s3", edges, 6);

        $display("[TB] scenario 4: back-to-back x^2+x+1 at x=2");
        pushA(8'd7, 1'b0);
        applyStimulus(1'b0, 8'd1, 1);
        checkOutput("valid_drop_b2b", rv_a, 0);
        checkOutput("result_hold_load", res_a, 69);
        applyStimulus(1'b0, 8'd1, 1);
        applyStimulus(1'b0, 8'd1, 1);
        applyStimulus(1'b0, 8'd2, 1);
        checkOutput("result_hold_compute", res_a, 69);
        waitDone(1'b0, edges, busy_cnt);

        $display("[TB] scenario 5: reset during MUL");
        loadAll(1'b0, '{8'd2, 8'd3, 8'd4, 8'd5, 8'd0}, 4, 1);
        @(negedge clk);
        checkOutput("busy_in_mul", busy_a, 1);
        reset = 1'b1;
        #1;
        checkOutput("midreset_result", res_a, 0);
        checkOutput("midreset_valid", rv_a, 0);
        checkOutput("midreset_overflow", ovf_a, 0);
        checkOutput("midreset_busy", busy_a, 0);
        @(negedge clk);
        reset = 1'b0;
        pushA(8'd69, 1'b0);
        loadAll(1'b0, '{8'd2, 8'd3, 8'd4, 8'd5, 8'd0}, 4, 1);
        waitDone(1'b0, edges, busy_cnt);

        $display("[TB] scenario 6: DEGREE=3 x^3+1 at x=3");
        e.result = 8'd28;
        e.ovf    = 1'b0;
        q_b.push_back(e);
        loadAll(1'b1, '{8'd1, 8'd0, 8'd0, 8'd1, 8'd3}, 5, 1);
        waitDone(1'b1, edges, busy_cnt);
        checkOutput("latency_d3", edges, 8);
        checkOutput("busy_cycles_d3", busy_cnt, 7);

        repeat (2) @(negedge clk);
        checkOutput("pending_a", q_a.size(), 0);
        checkOutput("pending_b", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global safety net in case a task stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no completion, expected finish before 2000000");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/poly_eval_horner.md
Name: poly_eval_horner

Overview:
- Evaluates a degree-DEGREE polynomial with Horner's method: P(x) = a_D*x^D + ... + a_1*x + a_0.
- Coefficients and x are entered one value at a time through the push-button Go / DataIn interface.
- A shared multiply/add datapath is sequenced by an FSM, with results truncated to WIDTH bits.
- This is the parametrised successor of the lab's fixed Ax^2+Bx+C evaluator. It adds arbitrary degree and a sticky overflow flag.

Parameters:
- WIDTH, 8: width of DataIn, coefficients, x, accumulator and DataResult.
- DEGREE, 2: polynomial degree. Legal range is 1..15. Coefficient storage is DEGREE+1 registers.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Go  in  1  load strobe (level, push-button style). One value is captured per high pulse.
- DataIn  in  WIDTH  coefficient or x value to capture.
- DataResult  out  WIDTH  P(x) mod 2^WIDTH. Holds its value until the next evaluation completes.
- ResultValid  out  1  high while DataResult holds a completed result not yet superseded by a new load.
- Overflow  out  1  high if any intermediate product or sum of the last evaluation exceeded WIDTH bits. Valid whenever ResultValid is high.
- Busy  out  1  high in states INIT, MUL and ADD.

Behaviour:
- Reset (async, any state, including mid-compute):
  - state goes to LOAD_COEF with idx = DEGREE.
  - All coefficients, x, acc, DataResult and Overflow clear to 0.
  - ResultValid and Busy go to 0.
- States and transitions:
  - LOAD_COEF:
    - If Go is sampled high, DataIn is written into coef[idx] and the FSM moves to COEF_WAIT.
    - Otherwise it stays.
  - COEF_WAIT:
    - It stays while Go is high; no further capture happens, however long Go is held.
    - When Go is low: if idx == 0, go to LOAD_X; else idx decrements and the FSM returns to LOAD_COEF.
  - Load order: coefficients load highest first, a_D down to a_0.
  - LOAD_X: if Go is high, DataIn is written into x and the FSM moves to X_WAIT.
  - X_WAIT: it stays while Go is high. When Go is low, it goes to INIT.
  - INIT: acc <= coef[DEGREE], step <= DEGREE-1, Overflow <= 0. Next state is MUL.
  - MUL:
    - acc <= low WIDTH bits of acc*x, using a full 2*WIDTH product.
    - Overflow |= (upper WIDTH bits != 0).
    - Next state is ADD.
  - ADD:
    - acc <= low WIDTH bits of acc+coef[step]; Overflow |= carry-out.
    - If step == 0: DataResult <= new acc value and the FSM goes to DONE.
    - Otherwise: step decrements and the FSM goes to MUL.
  - DONE:
    - ResultValid = 1.
    - It behaves exactly as LOAD_COEF with idx = DEGREE: Go high captures coef[DEGREE] and moves to COEF_WAIT.
    - ResultValid drops on that edge.
- Latency: DONE is entered 2*DEGREE+2 rising edges after the edge on which X_WAIT samples Go low. For DEGREE=2 this is 6.
- Go is ignored in INIT, MUL and ADD. The evaluation cannot be aborted except by Reset.
- Coefficients and x are retained after DONE. Each new evaluation requires a full reload of all DEGREE+2 values.
- Arithmetic is unsigned and modulo 2^WIDTH.
- Idle-state outputs:
  - ResultValid is 0 in all states except DONE.
  - DataResult keeps its previous result during the loads and compute of the next evaluation.
  - Overflow keeps the previous value until INIT.
- ResultValid, Busy and Overflow are Moore-style: decoded from state or taken from registers, never combinational from Go.

Decomposition:
- Package poly_pkg:
  - state enum (LOAD_COEF, COEF_WAIT, LOAD_X, X_WAIT, INIT, MUL, ADD, DONE).
  - ALU op enum (OP_ADD, OP_MUL).
- Natural sub-module poly_eval_datapath:
  - coefficient register file and x register.
  - acc, the single shared ALU and the overflow detect.
  - DataResult register.
- The FSM and the idx/step counters live in the top module.

Test Plan:
- WIDTH=8, DEGREE=2; load 2, 3, 4, then x=5 → DataResult=69 (0x45), Overflow=0, ResultValid high 6 edges after Go releases on x.
- WIDTH=8, DEGREE=2; load 16, 0, 0, x=4 → DataResult=0, Overflow=1 (16*4=64, then 64*4=256).
- Go held high for 20 cycles on each value, with DataIn changing while Go is high → only the first sampled value is captured, so the second run of scenario 1 still gives 69.
- Back-to-back: after DONE, load 1, 1, 1, x=2 → ResultValid drops on the first Go, DataResult stays 69 until the new DONE, then becomes 7.
- Reset asserted mid-compute (in MUL) → all outputs 0 immediately; subsequent full load of scenario 1 gives 69.
- WIDTH=8, DEGREE=3; load 1, 0, 0, 1, x=3 → DataResult=28, latency 8 edges, Busy high for exactly 7 cycles.
